edp_mdu: RTL and testbench
==========================

# edp_mdu

Parametrised iterative multiply/divide unit for the EBOX data path. It uses the AR/MQ/BR register model: AR holds the high result, MQ the low result, BR the operand. Signed and unsigned operations are computed one bit per clock with a start/done handshake. It sits beside the EDP adders and serves multi-cycle MUL/DIV microcode steps. Divide overflow ("no divide") is detected up front and leaves the operands intact, as the processor's semantics require.

## Interface
Parameters:
- `WIDTH`, 36: operand width; results are 2×WIDTH.
- `CNT_W`, $clog2(WIDTH+1): iteration counter width. Derived; do not override.

Ports:
- `clk`  in  1  data path clock.
- `reset`  in  1  reset, synchronous, active-high.
- `start`  in  1  request; accepted only in IDLE.
- `op`  in  2  operation: 00 MUL signed, 01 MULU, 10 DIV signed, 11 DIVU.
- `a_hi`  in  WIDTH  dividend high word; ignored for multiply.
- `a_lo`  in  WIDTH  dividend low word, or multiplier.
- `b`  in  WIDTH  multiplicand or divisor (BR).
- `abort`  in  1  cancels the operation in flight.
- `busy`  out  1  high from the accept edge until the done cycle, exclusive.
- `done`  out  1  one-cycle pulse; results are valid from this cycle on.
- `hi`  out  WIDTH  AR: product high word or remainder.
- `lo`  out  WIDTH  MQ: product low word or quotient.
- `no_divide`  out  1  divide overflow flag; updated with every done.

## Operation
- Reset values: `busy`=0, `done`=0, `hi`=0, `lo`=0, `no_divide`=0, state IDLE.
- States: IDLE → PREP → ITER → FIXUP → IDLE.
  - **IDLE**: `start`=1 captures `op`, `a_hi`, `a_lo`, `b`.
  - **PREP**, one cycle:
    - Signed ops take magnitudes of the operands and record the result signs: product or quotient sign = sign(a)^sign(b); remainder sign = sign of the 2W dividend.
    - Divide checks overflow. Overflow is divisor magnitude 0, or (dividend magnitude >> (W-1)) ≥ divisor magnitude for signed, or a_hi ≥ b for unsigned.
    - On overflow: go to IDLE with `done`=1 and `no_divide`=1; `hi`=a_hi and `lo`=a_lo (original values, not magnitudes).
  - **ITER**, exactly WIDTH cycles, counter WIDTH-1 down to 0:
    - Multiply: unsigned shift-add. If MQ[lsb], add BR to AR (W+1-bit sum), then shift {carry,AR,MQ} right one.
    - Divide: restoring. Shift {AR,MQ} left one, trial-subtract BR from the W+1-bit AR. If it is non-negative, keep the difference and set MQ[lsb]=1; otherwise restore.
  - **FIXUP**, one cycle:
    - Signed multiply: negate {AR,MQ} as a 2W value if the sign is set.
    - Signed divide: negate MQ by the quotient sign and AR by the remainder sign.
    - Then go to IDLE with `done`=1 and `no_divide`=0.
- Quotient −2^(W-1) is reported as overflow. This is intended behaviour, not a bug.
- `start` while busy is ignored; no queueing.
- `start` in the same cycle as `done` is accepted: back-to-back operation.
- `abort` in PREP, ITER or FIXUP: next state IDLE, `busy`=0, no `done` pulse, `no_divide` unchanged. `hi`/`lo` hold the partial contents and are not valid.
- `abort` in IDLE has no effect. When `abort` and `start` arrive together in IDLE, `start` wins.
- `reset` has priority over everything, including mid-operation; all outputs return to their reset values on the next edge.
- `hi`/`lo`/`no_divide` hold their values after `done` until the next accepted `start`.

## Timing
- Accept edge = the rising edge where IDLE and `start`=1.
- Normal latency: `done` is high in the cycle following edge accept+WIDTH+2, i.e. WIDTH+3 edges counting the accept edge. For WIDTH=36 that is 39.
- Overflow latency: `done` follows edge accept+1, i.e. 2 edges.
- `busy` rises on the accept edge and falls on the edge that raises `done`.
- `abort` takes effect on the next edge.
- All outputs are registered; there is no combinational input-to-output path.

## Structure
- Package `edp_mdu_pkg`:
  - `tMduOp` enum {mduMUL, mduMULU, mduDIV, mduDIVU}.
  - `tMduState` enum {mdsIDLE, mdsPREP, mdsITER, mdsFIXUP}.
- Sub-module `mdu_negate #(W)`: conditional two's-complement negate. Instantiated for the 2W product fixup, the W-bit magnitudes, and the W-bit quotient and remainder fixups.
- Single `always_ff` for state, counter, AR/MQ/BR and sign flags. Combinational next-value logic for the adder and subtractor.

## Test plan
All scenarios use WIDTH=36; values in octal.
- MULU, a_lo=3, b=5 → `done` 39 edges after accept; `hi`=0, `lo`=17, `no_divide`=0.
- MUL, a_lo=−2 (777777777776), b=3 → `hi`=777777777777, `lo`=777777777772. Also a_lo=b=400000000000 → `hi`=200000000000, `lo`=0.
- DIV, {a_hi,a_lo}={0,144}, b=−7 → `lo`=777777777762 (−14), `hi`=2, `no_divide`=0.
- Divide overflow:
  - DIVU, a_hi=5, b=5 → `done` 2 edges after accept, `no_divide`=1, `hi`=5, `lo`=a_lo unchanged.
  - DIV, b=0 → same response.
- Handshake:
  - `start` pulsed at accept+5 while busy → ignored, single `done`.
  - `start` held with `done` → second operation accepted immediately, correct result.
- Abort and reset:
  - `abort` at accept+10 → `busy`=0 next edge, no `done`; a following MULU 3×5 still yields `lo`=17.
  - `reset` at accept+20 → all outputs 0 next edge.

Source files
------------

// File: rtl/edp_mdu_pkg.sv
// Shared types for the EBOX data path multiply/divide unit.
package edp_mdu_pkg;

  typedef enum logic [1:0] {
    mduMUL  = 2'b00,
    mduMULU = 2'b01,
    mduDIV  = 2'b10,
    mduDIVU = 2'b11
  } tMduOp;

  typedef enum logic [1:0] {
    mdsIDLE,
    mdsPREP,
    mdsITER,
    mdsFIXUP
  } tMduState;

endpackage

// File: rtl/mdu_negate.sv
// Conditional two's-complement negate, used for magnitudes and sign fixups.
module mdu_negate #(
  parameter int W = 36
) (
  input  logic         i_neg,
  input  logic [W-1:0] i_val,
  output logic [W-1:0] o_val
);

  assign o_val = i_neg ? (~i_val + W'(1)) : i_val;

endmodule

// File: rtl/edp_mdu.sv
// Iterative AR/MQ/BR multiply/divide unit: one bit per clock, start/done handshake,
// up-front divide overflow detection that leaves the operands in AR/MQ.
module edp_mdu
  import edp_mdu_pkg::*;
#(
  parameter int WIDTH = 36,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a_hi,
  input  logic [WIDTH-1:0] a_lo,
  input  logic [WIDTH-1:0] b,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             no_divide
);

  tMduState           r_state;
  tMduState           w_state_nxt;
  tMduOp              r_op;
  logic [WIDTH-1:0]   r_ar;
  logic [WIDTH-1:0]   r_mq;
  logic [WIDTH-1:0]   r_br;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_sign_q;
  logic               r_sign_r;
  logic               r_busy;
  logic               r_done;
  logic               r_no_div;

  logic               w_is_div;
  logic               w_is_signed;
  logic [2*WIDTH-1:0] w_wide_in;
  logic               w_wide_neg;
  logic [2*WIDTH-1:0] w_wide_mag;
  logic [WIDTH-1:0]   w_br_mag;
  logic [WIDTH-1:0]   w_q_fix;
  logic [WIDTH-1:0]   w_r_fix;
  logic               w_ovf;
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH:0]     w_div_shift;
  logic               w_div_ge;
  logic [WIDTH-1:0]   w_div_sub;

  assign w_is_div    = (r_op == mduDIV) || (r_op == mduDIVU);
  assign w_is_signed = (r_op == mduMUL) || (r_op == mduDIV);

  // One 2W negator serves both the PREP magnitude (dividend or sign-extended
  // multiplier) and the FIXUP negation of the full product.
  assign w_wide_in  = (w_is_div || r_state == mdsFIXUP) ? {r_ar, r_mq}
                                                        : {{WIDTH{r_mq[WIDTH-1]}}, r_mq};
  assign w_wide_neg = (r_state == mdsFIXUP) ? r_sign_q
                                            : (w_is_signed & w_wide_in[2*WIDTH-1]);

  mdu_negate #(.W(2*WIDTH)) u_neg_wide (.i_neg(w_wide_neg), .i_val(w_wide_in), .o_val(w_wide_mag));
  mdu_negate #(.W(WIDTH)) u_neg_br (.i_neg(w_is_signed & r_br[WIDTH-1]), .i_val(r_br), .o_val(w_br_mag));
  mdu_negate #(.W(WIDTH)) u_neg_quo (.i_neg(r_sign_q), .i_val(r_mq), .o_val(w_q_fix));
  mdu_negate #(.W(WIDTH)) u_neg_rem (.i_neg(r_sign_r), .i_val(r_ar), .o_val(w_r_fix));

  // A quotient magnitude of 2^(W-1) or more does not fit, so -2^(W-1) also traps.
  assign w_ovf = w_is_div &&
                 ((w_br_mag == '0) ||
                  (w_is_signed ? (w_wide_mag[2*WIDTH-1:WIDTH-1] >= {1'b0, w_br_mag})
                               : (r_ar >= r_br)));

  assign w_mul_sum   = {1'b0, r_ar} + (r_mq[0] ? {1'b0, r_br} : '0);
  assign w_div_shift = {r_ar, r_mq[WIDTH-1]};
  assign w_div_ge    = w_div_shift >= {1'b0, r_br};
  assign w_div_sub   = w_div_shift[WIDTH-1:0] - r_br;

  // NOTE: assign the default first so every path writes w_state_nxt and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      mdsIDLE:  if (start) w_state_nxt = mdsPREP;
      mdsPREP:  w_state_nxt = w_ovf ? mdsIDLE : mdsITER;
      mdsITER:  if (r_cnt == '0) w_state_nxt = mdsFIXUP;
      mdsFIXUP: w_state_nxt = mdsIDLE;
      default:  w_state_nxt = mdsIDLE;
    endcase
    if (abort && r_state != mdsIDLE) w_state_nxt = mdsIDLE;
  end

  // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= mdsIDLE;
      r_op     <= mduMUL;
      r_ar     <= '0;
      r_mq     <= '0;
      r_br     <= '0;
      r_cnt    <= '0;
      r_sign_q <= 1'b0;
      r_sign_r <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_no_div <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= 1'b0;
      if (abort && r_state != mdsIDLE) begin
        r_busy <= 1'b0;
      end else begin
        case (r_state)
          mdsIDLE: if (start) begin
            r_op   <= tMduOp'(op);
            r_ar   <= a_hi;
            r_mq   <= a_lo;
            r_br   <= b;
            r_busy <= 1'b1;
          end
          mdsPREP: begin
            r_sign_q <= w_is_signed & ((w_is_div ? r_ar[WIDTH-1] : r_mq[WIDTH-1]) ^ r_br[WIDTH-1]);
            r_sign_r <= w_is_signed & r_ar[WIDTH-1];
            r_cnt    <= CNT_W'(WIDTH - 1);
            if (w_ovf) begin
              r_done   <= 1'b1;
              r_no_div <= 1'b1;
              r_busy   <= 1'b0;
            end else begin
              r_ar <= w_is_div ? w_wide_mag[2*WIDTH-1:WIDTH] : '0;
              r_mq <= w_wide_mag[WIDTH-1:0];
              r_br <= w_br_mag;
            end
          end
          mdsITER: begin
            r_cnt <= r_cnt - CNT_W'(1);
            if (w_is_div) begin
              r_ar <= w_div_ge ? w_div_sub : w_div_shift[WIDTH-1:0];
              r_mq <= {r_mq[WIDTH-2:0], w_div_ge};
            end else begin
              r_ar <= w_mul_sum[WIDTH:1];
              r_mq <= {w_mul_sum[0], r_mq[WIDTH-1:1]};
            end
          end
          mdsFIXUP: begin
            if (w_is_div) begin
              r_ar <= w_r_fix;
              r_mq <= w_q_fix;
            end else begin
              {r_ar, r_mq} <= w_wide_mag;
            end
            r_done   <= 1'b1;
            r_no_div <= 1'b0;
            r_busy   <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign hi        = r_ar;
  assign lo        = r_mq;
  assign no_divide = r_no_div;

endmodule

// File: tb/tb_edp_mdu.sv
// Self-checking bench for edp_mdu: directed scenarios plus randomized traffic
// compared every cycle against an arithmetic reference model.
module tb_edp_mdu;

  localparam int W        = 36;
  localparam int LAT_NORM = W + 2;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         nd;
  } res_t;

  logic         clk = 1'b0;
  logic         reset, start, abort;
  logic [1:0]   op;
  logic [W-1:0] a_hi, a_lo, b;
  logic         busy, done, no_divide;
  logic [W-1:0] hi, lo;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  edp_mdu #(.WIDTH(W)) u_dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .a_hi(a_hi), .a_lo(a_lo), .b(b), .abort(abort),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .no_divide(no_divide)
  );

  task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0o, expected %0o", name, act, exp);
    end
  endtask

  // Reference: full-width integer arithmetic, overflow when the quotient does not fit.
  function automatic res_t ref_model(input logic [1:0] f_op, input logic [W-1:0] f_ahi,
                                     input logic [W-1:0] f_alo, input logic [W-1:0] f_b);
    res_t r;
    logic [2*W-1:0]        ud, uq, ur;
    logic signed [2*W-1:0] sd, sv, sq, sr, qmax, smin;
    qmax = {{(W+1){1'b0}}, {(W-1){1'b1}}};
    smin = {1'b1, {(2*W-1){1'b0}}};
    r = '0;
    case (f_op)
      2'b00: {r.hi, r.lo} = $signed({{W{f_alo[W-1]}}, f_alo}) * $signed({{W{f_b[W-1]}}, f_b});
      2'b01: {r.hi, r.lo} = {{W{1'b0}}, f_alo} * {{W{1'b0}}, f_b};
      2'b10: begin
        sd = $signed({f_ahi, f_alo});
        sv = $signed({{W{f_b[W-1]}}, f_b});
        if (f_b == '0 || (sd == smin && sv == -1)) begin
          r.nd = 1'b1;
        end else begin
          sq = sd / sv;
          sr = sd % sv;
          if (sq > qmax || sq < -qmax) r.nd = 1'b1;
          else begin r.hi = sr[W-1:0]; r.lo = sq[W-1:0]; end
        end
      end
      default: begin
        ud = {f_ahi, f_alo};
        if (f_b == '0) begin
          r.nd = 1'b1;
        end else begin
          uq = ud / {{W{1'b0}}, f_b};
          ur = ud % {{W{1'b0}}, f_b};
          if (uq[2*W-1:W] != '0) r.nd = 1'b1;
          else begin r.hi = ur[W-1:0]; r.lo = uq[W-1:0]; end
        end
      end
    endcase
    if (r.nd) begin r.hi = f_ahi; r.lo = f_alo; end
    return r;
  endfunction

  function automatic logic [W-1:0] rand36();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[W-1:0];
  endfunction

  // Cycle-level expectation: remaining edges until done, last completed result.
  res_t w_ref;
  res_t m_pend, m_out;
  int   m_rem = 0;
  bit   m_init = 1'b0, m_exp_done = 1'b0, m_valid = 1'b0;

  assign w_ref = ref_model(op, a_hi, a_lo, b);

  always @(posedge clk) begin
    m_exp_done <= 1'b0;
    if (reset) begin
      m_init  <= 1'b1;
      m_rem   <= 0;
      m_out   <= '0;
      m_valid <= 1'b1;
    end else if (m_rem == 0) begin
      if (start) begin
        m_pend  <= w_ref;
        m_rem   <= w_ref.nd ? 1 : LAT_NORM;
        m_valid <= 1'b0;
      end
    end else if (abort) begin
      m_rem   <= 0;
      m_valid <= 1'b0;
    end else begin
      m_rem <= m_rem - 1;
      if (m_rem == 1) begin
        m_exp_done <= 1'b1;
        m_out      <= m_pend;
        m_valid    <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      check("done", 72'(done), 72'(m_exp_done));
      check("busy", 72'(busy), 72'(m_rem != 0));
      check("no_divide", 72'(no_divide), 72'(m_out.nd));
      if (m_valid) begin
        check("hi", 72'(hi), 72'(m_out.hi));
        check("lo", 72'(lo), 72'(m_out.lo));
      end
    end
  end

  task automatic do_op(input string name, input logic [1:0] t_op, input logic [W-1:0] t_ahi,
                       input logic [W-1:0] t_alo, input logic [W-1:0] t_b,
                       input logic [W-1:0] e_hi, input logic [W-1:0] e_lo, input logic e_nd,
                       input int e_lat);
    int lat;
    @(negedge clk);
    start = 1'b1; op = t_op; a_hi = t_ahi; a_lo = t_alo; b = t_b;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 200) begin @(negedge clk); lat++; end
    check({name, " latency"}, 72'(lat), 72'(e_lat));
    check({name, " hi"}, 72'(hi), 72'(e_hi));
    check({name, " lo"}, 72'(lo), 72'(e_lo));
    check({name, " no_divide"}, 72'(no_divide), 72'(e_nd));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    res_t r;
    int   n_done, k;
    logic [W-1:0] got_lo;

    reset = 1'b1; start = 1'b0; abort = 1'b0; op = 2'b00;
    a_hi = '0; a_lo = '0; b = '0;

    r = ref_model(2'b00, '0, 36'o777777777776, 36'o3);
    check("model MUL hi", 72'(r.hi), 72'(36'o777777777777));
    check("model MUL lo", 72'(r.lo), 72'(36'o777777777772));
    r = ref_model(2'b10, '0, 36'o144, 36'o777777777771);
    check("model DIV lo", 72'(r.lo), 72'(36'o777777777762));
    check("model DIV hi", 72'(r.hi), 72'(36'o2));
    r = ref_model(2'b11, 36'o5, 36'o1234, 36'o5);
    check("model DIVU ovf", 72'(r.nd), 72'(1'b1));

    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset busy", 72'(busy), 72'(0));
    check("reset hi", 72'(hi), 72'(0));
    check("reset lo", 72'(lo), 72'(0));

    do_op("MULU 3x5", 2'b01, '0, 36'o3, 36'o5, '0, 36'o17, 1'b0, 39);
    do_op("MUL -2x3", 2'b00, '0, 36'o777777777776, 36'o3, 36'o777777777777, 36'o777777777772, 1'b0, 39);
    do_op("MUL min x min", 2'b00, '0, 36'o400000000000, 36'o400000000000, 36'o200000000000, '0, 1'b0, 39);
    do_op("DIV 100/-7", 2'b10, '0, 36'o144, 36'o777777777771, 36'o2, 36'o777777777762, 1'b0, 39);
    do_op("DIVU ovf", 2'b11, 36'o5, 36'o1234, 36'o5, 36'o5, 36'o1234, 1'b1, 2);
    do_op("DIV by zero", 2'b10, 36'o1, 36'o2, '0, 36'o1, 36'o2, 1'b1, 2);

    // Reset mid-operation.
    @(negedge clk);
    start = 1'b1; op = 2'b00; a_lo = 36'o7777; b = 36'o4321;
    @(negedge clk);
    start = 1'b0;
    repeat (18) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midreset busy", 72'(busy), 72'(0));
    check("midreset done", 72'(done), 72'(0));
    check("midreset hi", 72'(hi), 72'(0));
    check("midreset lo", 72'(lo), 72'(0));
    check("midreset no_divide", 72'(no_divide), 72'(0));
    reset = 1'b0;

    // start pulsed while busy is ignored.
    @(negedge clk);
    start = 1'b1; op = 2'b01; a_hi = '0; a_lo = 36'o7; b = 36'o6;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1; a_lo = 36'o13; b = 36'o15;
    @(negedge clk);
    start = 1'b0;
    n_done = 0; got_lo = '0;
    repeat (60) begin
      @(negedge clk);
      if (done) begin n_done++; got_lo = lo; end
    end
    check("busy start done count", 72'(n_done), 72'(1));
    check("busy start lo", 72'(got_lo), 72'(36'o52));

    // start held through done: back-to-back accept.
    @(negedge clk);
    start = 1'b1; op = 2'b01; a_hi = '0; a_lo = 36'o3; b = 36'o5;
    @(negedge clk);
    op = 2'b11; a_hi = '0; a_lo = 36'o144; b = 36'o7;
    k = 1;
    while (!done && k < 200) begin @(negedge clk); k++; end
    check("b2b first lo", 72'(lo), 72'(36'o17));
    @(negedge clk);
    start = 1'b0;
    k = 1;
    while (!done && k < 200) begin @(negedge clk); k++; end
    check("b2b second latency", 72'(k), 72'(39));
    check("b2b second lo", 72'(lo), 72'(36'o16));
    check("b2b second hi", 72'(hi), 72'(36'o2));

    // Abort mid-operation.
    @(negedge clk);
    start = 1'b1; op = 2'b01; a_lo = 36'o123; b = 36'o456;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort busy", 72'(busy), 72'(0));
    n_done = 0;
    repeat (45) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("abort no done", 72'(n_done), 72'(0));
    do_op("MULU after abort", 2'b01, '0, 36'o3, 36'o5, '0, 36'o17, 1'b0, 39);

    // Randomized traffic: starts, starts while busy, aborts and rare resets.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      start = ($urandom % 3) != 0;
      op    = 2'($urandom % 4);
      abort = ($urandom % 120) == 0;
      reset = ($urandom % 1000) == 0;
      b     = ($urandom % 4 == 0) ? W'($urandom % 16) : rand36();
      a_lo  = rand36();
      case ($urandom % 3)
        0:       a_hi = rand36();
        1:       a_hi = {W{a_lo[W-1]}};
        default: a_hi = (b == '0) ? '0 : rand36() % b;
      endcase
    end
    @(negedge clk);
    start = 1'b0; abort = 1'b0; reset = 1'b0;
    repeat (50) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
